bus_arbiter_rr: RTL and testbench

Round-robin arbiter and transaction sequencer for the shared device bus. It accepts one-hot-per-device bus requests (BARQ) and grants the bus to exactly one device (BAGD). It then drives the address/data handshake with the addressed target (AddressValid, TargetReady, DataStrobe) and reports aborted transactions on Error. It sits between the requesting devices and the bus target and is the only driver of BAGD.

---
 rtl/bus_arbiter_rr.sv | 174 +++++++++++++++++
 tb/tb_bus_arbiter_rr.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: round-robin bus arbiter and address/data transaction sequencer.
// Grants the shared bus to one requester at a time. It then runs the address
// handshake with timeout and the data phase, and reports aborted transactions on Error.
// Optional feature macro: ARBITER_HOLD_LIMIT_EN. When it is defined, a grant is
// preempted after MaxHoldCycles cycles in the data phase.
module bus_arbiter_rr #(
  parameter int unsigned DeviceMaxNumber = 4,
  parameter int unsigned TimeoutCycles   = 16,
  parameter int unsigned MaxHoldCycles   = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DeviceMaxNumber-1:0] BARQ,
  output logic [DeviceMaxNumber-1:0] BAGD,
  output logic                       AddressValid,
  input  logic                       TargetReady,
  output logic                       DataStrobe,
  output logic [1:0]                 Error
);

  localparam int unsigned IdxW = $clog2(DeviceMaxNumber);
  localparam int unsigned AtW  = $clog2(TimeoutCycles);

  localparam logic [IdxW-1:0] LastRst = IdxW'(DeviceMaxNumber - 1);
  localparam logic [AtW-1:0]  AtMax   = AtW'(TimeoutCycles - 1);

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_DROP    = 2'b10;

`ifdef ARBITER_HOLD_LIMIT_EN
  localparam int unsigned     HtW   = $clog2(MaxHoldCycles);
  localparam logic [HtW-1:0]  HtMax = HtW'(MaxHoldCycles - 1);
  localparam logic [1:0]      ERR_HOLD = 2'b11;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RELEASE
  } state_e;

  state_e                     state_q, state_d;
  logic [DeviceMaxNumber-1:0] bagd_q, bagd_d;
  logic [IdxW-1:0]            last_q, last_d;
  logic [1:0]                 error_q, error_d;
  logic                       av_q, av_d;
  logic [AtW-1:0]             at_q, at_d;
`ifdef ARBITER_HOLD_LIMIT_EN
  logic [HtW-1:0]             ht_q, ht_d;
`endif

  logic                       arb_found;
  logic [IdxW-1:0]            arb_idx;
  logic [DeviceMaxNumber-1:0] arb_onehot;
  logic                       owner_req;

  // Round-robin search starting one past the last granted device.
  always_comb begin
    arb_found  = 1'b0;
    arb_idx    = '0;
    for (int unsigned off = 1; off <= DeviceMaxNumber; off++) begin
      if (!arb_found &&
          BARQ[IdxW'((32'(last_q) + off) % DeviceMaxNumber)]) begin
        arb_found = 1'b1;
        arb_idx   = IdxW'((32'(last_q) + off) % DeviceMaxNumber);
      end
    end
    arb_onehot = DeviceMaxNumber'(1) << arb_idx;
  end

  // last_q always holds the current owner while a grant is active.
  assign owner_req = BARQ[last_q];

  // Next-state, grant, status and timer updates.
  always_comb begin
    state_d = state_q;
    bagd_d  = bagd_q;
    last_d  = last_q;
    error_d = error_q;
    av_d    = 1'b0;
    at_d    = at_q;
`ifdef ARBITER_HOLD_LIMIT_EN
    ht_d    = ht_q;
`endif
    unique case (state_q)
      ST_IDLE, ST_RELEASE: begin
        bagd_d  = '0;
        state_d = ST_IDLE;
        if (arb_found) begin
          state_d = ST_ADDR;
          bagd_d  = arb_onehot;
          last_d  = arb_idx;
          error_d = ERR_OK;
          av_d    = 1'b1;
          at_d    = '0;
`ifdef ARBITER_HOLD_LIMIT_EN
          ht_d    = '0;
`endif
        end
      end
      ST_ADDR: begin
        av_d = 1'b1;
        if (!owner_req) begin
          error_d = ERR_DROP;
          state_d = ST_RELEASE;
          bagd_d  = '0;
          av_d    = 1'b0;
        end else if (TargetReady) begin
          state_d = ST_DATA;
          av_d    = 1'b0;
        end else if (at_q == AtMax) begin
          error_d = ERR_TIMEOUT;
          state_d = ST_RELEASE;
          bagd_d  = '0;
          av_d    = 1'b0;
        end else begin
          at_d = at_q + AtW'(1);
        end
      end
      ST_DATA: begin
        if (!owner_req) begin
          state_d = ST_RELEASE;
          bagd_d  = '0;
        end
`ifdef ARBITER_HOLD_LIMIT_EN
        else if (ht_q == HtMax) begin
          error_d = ERR_HOLD;
          state_d = ST_RELEASE;
          bagd_d  = '0;
        end else begin
          ht_d = ht_q + HtW'(1);
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
        bagd_d  = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      bagd_q  <= '0;
      last_q  <= LastRst;
      error_q <= ERR_OK;
      av_q    <= 1'b0;
      at_q    <= '0;
`ifdef ARBITER_HOLD_LIMIT_EN
      ht_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      bagd_q  <= bagd_d;
      last_q  <= last_d;
      error_q <= error_d;
      av_q    <= av_d;
      at_q    <= at_d;
`ifdef ARBITER_HOLD_LIMIT_EN
      ht_q    <= ht_d;
`endif
    end
  end

  assign BAGD         = bagd_q;
  assign AddressValid = av_q;
  assign Error        = error_q;
  assign DataStrobe   = (state_q == ST_DATA) && TargetReady;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Testbench for bus_arbiter_rr: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a transaction-level model.
module tb_bus_arbiter_rr;

  localparam int N  = 4;
  localparam int TO = 16;
  localparam int MH = 64;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] barq = '0;
  logic [N-1:0] bagd;
  logic         av;
  logic         tr = 1'b0;
  logic         ds;
  logic [1:0]   err;

  int total = 0;
  int bad = 0;
  int ds_cnt = 0;
  bit checking = 1'b0;

  // model: phase 0 idle, 1 address, 2 data, 3 turnaround
  int         m_ph = 0;
  int         m_last = N - 1;
  int         m_own = 0;
  int         m_acnt = 0;
  int         m_dcnt = 0;
  logic [1:0] m_err = 2'b00;

  bus_arbiter_rr #(
    .DeviceMaxNumber(N),
    .TimeoutCycles(TO),
    .MaxHoldCycles(MH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .BARQ(barq),
    .BAGD(bagd),
    .AddressValid(av),
    .TargetReady(tr),
    .DataStrobe(ds),
    .Error(err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int arb(input logic [N-1:0] rq, input int last);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (rq[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_update();
    int p;
    if (reset) begin
      m_ph = 0; m_last = N - 1; m_err = 2'b00; m_own = 0;
    end else begin
      case (m_ph)
        0, 3: begin
          p = arb(barq, m_last);
          if (p >= 0) begin
            m_own = p; m_last = p; m_err = 2'b00;
            m_acnt = 0; m_dcnt = 0; m_ph = 1;
          end else m_ph = 0;
        end
        1: begin
          if (!barq[m_own]) begin m_err = 2'b10; m_ph = 3; end
          else if (tr) m_ph = 2;
          else begin
            m_acnt++;
            if (m_acnt == TO) begin m_err = 2'b01; m_ph = 3; end
          end
        end
        2: begin
          if (!barq[m_own]) m_ph = 3;
`ifdef ARBITER_HOLD_LIMIT_EN
          else begin
            m_dcnt++;
            if (m_dcnt == MH) begin m_err = 2'b11; m_ph = 3; end
          end
`endif
        end
        default: m_ph = 0;
      endcase
    end
  endtask

  // One bus cycle: model follows the edge, outputs compared at the falling edge.
  task automatic step();
    logic [N-1:0] e_bagd;
    @(posedge clk);
    model_update();
    @(negedge clk);
    if (checking) begin
      e_bagd = (m_ph == 1 || m_ph == 2) ? N'(1) << m_own : '0;
      chk("bagd", 32'(bagd), 32'(e_bagd));
      chk("addr_valid", 32'(av), 32'(m_ph == 1));
      chk("data_strobe", 32'(ds), 32'(m_ph == 2 && tr));
      chk("error", 32'(err), 32'(m_err));
      if (ds === 1'b1) ds_cnt++;
    end
  endtask

  initial begin
    int n;
    int cnt;
    int ds_base;
    logic [N-1:0] g;
    logic [N-1:0] exp_g [5];
    int pat [6];
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
    exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
    pat[0] = 0; pat[1] = 1; pat[2] = 0; pat[3] = 0; pat[4] = 1; pat[5] = 0;

    // reset
    reset = 1'b1; barq = '0; tr = 1'b0;
    step(); step();
    checking = 1'b1;
    reset = 1'b0;
    step();
    chk("reset_bagd", 32'(bagd), 32'd0);
    chk("reset_av", 32'(av), 32'd0);
    chk("reset_err", 32'(err), 32'd0);

    // round robin with all devices requesting
    barq = 4'b1111;
    step();
    for (int i = 0; i < 5; i++) begin
      n = 0;
      while (bagd == '0 && n < 4) begin step(); n++; end
      g = bagd;
      chk("rr_grant", 32'(g), 32'(exp_g[i]));
      tr = 1'b1;
      step();
      tr = 1'b0;
      barq = 4'b1111 & ~g;
      step();
      chk("rr_gap", 32'(bagd), 32'd0);
      barq = (i == 4) ? 4'b0000 : 4'b1111;
      step();
    end
    step();

    // address timeout
    barq = 4'b0100; tr = 1'b0;
    step();
    cnt = 0;
    while (av === 1'b1 && cnt < 40) begin cnt++; step(); end
    chk("timeout_av_cycles", 32'(cnt), 32'd16);
    chk("timeout_bagd", 32'(bagd), 32'd0);
    chk("timeout_err", 32'(err), 32'd1);
    barq = '0;
    step();

    // drop and TargetReady together in the address phase
    barq = 4'b0001;
    step();
    chk("drop_grant", 32'(bagd), 32'd1);
    ds_base = ds_cnt;
    barq = '0; tr = 1'b1;
    step();
    chk("drop_err", 32'(err), 32'd2);
    tr = 1'b0;
    step();
    chk("drop_no_strobe", 32'(ds_cnt - ds_base), 32'd0);

    // three data beats, then release
    barq = 4'b1000;
    step();
    ds_base = ds_cnt;
    tr = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      tr = pat[i][0];
      step();
    end
    barq = '0; tr = 1'b0;
    step();
    chk("beats_count", 32'(ds_cnt - ds_base), 32'd3);
    chk("beats_err", 32'(err), 32'd0);
    step();

    // reset in the middle of the data phase
    barq = 4'b0010;
    step();
    tr = 1'b1;
    step();
    chk("mid_data_bagd", 32'(bagd), 32'd2);
    reset = 1'b1; tr = 1'b0;
    step();
    chk("mid_reset_bagd", 32'(bagd), 32'd0);
    chk("mid_reset_av", 32'(av), 32'd0);
    chk("mid_reset_err", 32'(err), 32'd0);
    reset = 1'b0;
    step();
    chk("post_reset_grant", 32'(bagd), 32'd2);
    barq = '0;
    step(); step();

    // long hold with a competing request pending
    barq = 4'b0011;
    step();
    chk("hold_first_grant", 32'(bagd), 32'd1);
    tr = 1'b1;
    step();
    tr = 1'b0;
    for (int i = 0; i < 63; i++) step();
    chk("hold_last_cycle", 32'(bagd), 32'd1);
    step();
`ifdef ARBITER_HOLD_LIMIT_EN
    chk("hold_preempt_bagd", 32'(bagd), 32'd0);
    chk("hold_preempt_err", 32'(err), 32'd3);
    step();
    chk("hold_next_grant", 32'(bagd), 32'd2);
`else
    chk("hold_keep_bagd", 32'(bagd), 32'd1);
    chk("hold_keep_err", 32'(err), 32'd0);
    for (int i = 0; i < 20; i++) step();
    chk("hold_keep_late", 32'(bagd), 32'd1);
`endif
    barq = '0;
    step(); step(); step();

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 7) == 0) barq[b] = ~barq[b];
      tr = ($urandom_range(0, 2) == 0);
      step();
    end
    reset = 1'b0; barq = '0; tr = 1'b0;
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
